setup_config: RTL

- Configuration-menu responder for the door-lock controller's setup handshake.
- Activated by `setup_on`. Snapshots the current configuration (`data_setup_old`), then walks the user through an ordered keypad menu.
- Returns the edited configuration on `data_setup_new` with a one-cycle `setup_end` pulse.
- Sits beside the operational FSM and shares the keypad bus with it. Master PIN is never edited here.

---
 rtl/setup_config.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/setup_config.sv
// Setup-menu responder: snapshots the lock configuration, walks the keypad menu,
// and hands back the edited (or, on timeout, original) configuration with setup_end.
package setup_config_pkg;
    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    // pins[0] is PIN1 ... pins[3] is PIN4; time fields are in clock ticks
    typedef struct packed {
        logic           bip_status;
        logic [15:0]    bip_time;
        logic [15:0]    tranca_aut_time;
        pinPac_t        master_pin;
        pinPac_t [3:0]  pins;
    } setupPac_t;
endpackage

module setup_config
    import setup_config_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int TIMEOUT_SEC   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_on,
    input  setupPac_t  data_setup_old,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       setup_end,
    output setupPac_t  data_setup_new,
    output logic [3:0] setup_step,
    output logic [2:0] entry_count,
    output logic       setup_error
);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_SEC * TICKS_PER_SEC);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_BIP_STATUS  = 4'd1,
        S_BIP_TIME    = 4'd2,
        S_TRANCA_TIME = 4'd3,
        S_PIN1        = 4'd4,
        S_PIN2        = 4'd5,
        S_PIN3        = 4'd6,
        S_PIN4        = 4'd7,
        S_DONE        = 4'd8
    } state_e;

    state_e          state_q, state_d;
    setupPac_t       work_q, work_d, backup_q, backup_d, new_q, new_d;
    logic [3:0][3:0] buf_q, buf_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            key_valid_q, setup_on_q;

    logic            key_rise, on_rise, advance, clear;
    logic [2:0]      limit;
    logic [6:0]      dec_val;
    logic [1:0]      pin_idx;

    assign key_rise = key_valid & ~key_valid_q;
    assign on_rise  = setup_on & ~setup_on_q;
    assign pin_idx  = state_q[1:0];
    assign dec_val  = (cnt_q == 3'd1) ? 7'(buf_q[0])
                                      : 7'(buf_q[0]) * 7'd10 + 7'(buf_q[1]);

    always_comb begin
        case (state_q)
            S_BIP_STATUS:              limit = 3'd1;
            S_BIP_TIME, S_TRANCA_TIME: limit = 3'd2;
            default:                   limit = 3'd4;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        backup_d = backup_q;
        new_d    = new_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
        advance  = 1'b0;
        clear    = 1'b0;

        case (state_q)
            S_IDLE: begin
                clear = 1'b1;
                tmo_d = '0;
                if (on_rise) begin
                    work_d   = data_setup_old;
                    backup_d = data_setup_old;
                    state_d  = S_BIP_STATUS;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // abort beats timeout beats key
                if (!setup_on) begin
                    clear   = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_q >= TMO_LIMIT - 32'd1) begin
                    clear   = 1'b1;
                    new_d   = backup_q;
                    state_d = S_DONE;
                end else if (key_rise) begin
                    tmo_d = '0;
                    if (key_code <= 4'h9) begin
                        if (cnt_q < limit) begin
                            buf_d[cnt_q[1:0]] = key_code;
                            cnt_d             = cnt_q + 3'd1;
                        end
                    end else if (key_code == 4'hE) begin
                        clear = 1'b1;
                    end else if (key_code == 4'hF) begin
                        if (cnt_q == 3'd0) begin
                            advance = 1'b1;
                        end else begin
                            clear = 1'b1;
                            case (state_q)
                                S_BIP_STATUS: begin
                                    advance = (dec_val <= 7'd1);
                                    if (advance) work_d.bip_status = dec_val[0];
                                end
                                S_BIP_TIME: begin
                                    advance = (dec_val >= 7'd10) && (dec_val <= 7'd60);
                                    if (advance)
                                        work_d.bip_time = 16'(32'(dec_val) * 32'(TICKS_PER_SEC));
                                end
                                S_TRANCA_TIME: begin
                                    advance = (dec_val >= 7'd5) && (dec_val <= 7'd60);
                                    if (advance)
                                        work_d.tranca_aut_time = 16'(32'(dec_val) * 32'(TICKS_PER_SEC));
                                end
                                default: begin
                                    advance = (cnt_q == 3'd4);
                                    if (advance) begin
                                        work_d.pins[pin_idx].status = 1'b1;
                                        work_d.pins[pin_idx].digit1 = buf_q[0];
                                        work_d.pins[pin_idx].digit2 = buf_q[1];
                                        work_d.pins[pin_idx].digit3 = buf_q[2];
                                        work_d.pins[pin_idx].digit4 = buf_q[3];
                                    end
                                end
                            endcase
                            err_d = ~advance;
                        end
                    end else if (key_code == 4'hB) begin
                        if (state_q == S_PIN1) begin
                            err_d = 1'b1;
                        end else if (state_q >= S_PIN2) begin
                            work_d.pins[pin_idx].status = 1'b0;
                            advance = 1'b1;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
        endcase

        if (clear || advance) begin
            buf_d = '0;
            cnt_d = '0;
        end
        if (advance) begin
            state_d = state_e'(state_q + 4'd1);
            if (state_q == S_PIN4) new_d = work_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            backup_q    <= '0;
            new_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
            setup_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            backup_q    <= backup_d;
            new_q       <= new_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            key_valid_q <= key_valid;
            setup_on_q  <= setup_on;
        end
    end

    assign setup_end      = (state_q == S_DONE);
    assign data_setup_new = new_q;
    assign setup_step     = state_q;
    assign entry_count    = cnt_q;
    assign setup_error    = err_q;
endmodule
